// File: rtl/aes_key_scheduler.sv
// AES-128 round-key generator: expands a cipher key into round keys 0..10,
// streamed one per cycle over a valid/ready handshake.

module sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX_TBL[data_i];

endmodule

module aes_key_scheduler (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(10);
  localparam logic [7:0]       RCON_INIT  = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [WORD_W-1:0]  rot_w, sub_w, t_w;
  logic [WORD_W-1:0]  w0_n, w1_n, w2_n, w3_n;
  logic [KEY_W-1:0]   next_key;
  logic [7:0]         rcon_next;

  // RotWord of w3, then SubWord through one S-box per byte
  assign rot_w = {key_q[23:0], key_q[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    sbox u_sbox (
      .data_i (rot_w[8*b +: 8]),
      .data_o (sub_w[8*b +: 8])
    );
  end

  assign t_w       = sub_w ^ {rcon_q, 24'h000000};
  assign w0_n      = key_q[127:96] ^ t_w;
  assign w1_n      = key_q[95:64]  ^ w0_n;
  assign w2_n      = key_q[63:32]  ^ w1_n;
  assign w3_n      = key_q[31:0]   ^ w2_n;
  assign next_key  = {w0_n, w1_n, w2_n, w3_n};
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // Next-state and output decode; key/round are zeroed outside RUN so the
  // round-key outputs read zero whenever no key is being offered.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = '0;
          rcon_d  = RCON_INIT;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            key_d   = '0;
            round_d = '0;
            rcon_d  = RCON_INIT;
            state_d = FINISH;
          end else begin
            key_d   = next_key;
            round_d = round_q + RND_W'(1);
            rcon_d  = rcon_next;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: begin
        key_d   = '0;
        round_d = '0;
        rcon_d  = RCON_INIT;
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == RUN);
    valid_d = (state_d == RUN);
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_data  = key_q;
  assign rk_round = round_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Bench for aes_key_scheduler: FIPS-197 style key-expansion model with an
// S-box derived from GF(2^8) inversion, checked against the DUT every cycle.

module tb_aes_key_scheduler;

  typedef logic [127:0] key_arr_t [11];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b1;
  logic         busy, rk_valid, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_key_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .done     (done)
  );

  localparam logic [127:0] KA = 128'h6920e299a5202a6d656e636869746f2a;
  localparam logic [127:0] KF = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  task automatic expand(input logic [127:0] k, output key_arr_t ks);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_m[tmp[31:24]], sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Transaction-level expectation: 0 idle, 1 offering key m_idx, 2 done pulse
  int       m_phase = 0;
  int       m_idx = 0;
  key_arr_t m_keys;
  bit       chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_idx   = 0;
      chk_en  = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          expand(key_in, m_keys);
          m_idx   = 0;
          m_phase = 1;
        end
        1: if (rk_ready) begin
          if (m_idx == 10) m_phase = 2;
          else m_idx++;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",  128'(busy),     128'(m_phase == 1));
      chk("cyc_valid", 128'(rk_valid), 128'(m_phase == 1));
      chk("cyc_done",  128'(done),     128'(m_phase == 2));
      chk("cyc_round", 128'(rk_round), (m_phase == 1) ? 128'(m_idx) : 128'h0);
      chk("cyc_data",  rk_data,        (m_phase == 1) ? m_keys[m_idx] : 128'h0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic kick(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_round(input int r, input int lim);
    int n = 0;
    while (!(rk_valid === 1'b1 && rk_round === 4'(r))) begin
      if (n >= lim) begin
        checks++;
        errors++;
        $display("FAIL wait_round%0d timeout actual=none required=round %0d", r, r);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (done !== 1'b1) begin
      if (n >= lim) begin
        checks++;
        errors++;
        $display("FAIL wait_done timeout actual=no done required=done");
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  key_arr_t km;
  int       n;
  int       dn;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy",  128'(busy),     128'h0);
    chk("rst_valid", 128'(rk_valid), 128'h0);
    chk("rst_done",  128'(done),     128'h0);
    chk("rst_data",  rk_data,        128'h0);
    chk("rst_round", 128'(rk_round), 128'h0);
    reset = 1'b0;

    // Model pins against published expansions
    expand(128'h0, km);
    chk("pin_z_r1",  km[1],  128'h62636363626363636263636362636363);
    chk("pin_z_r2",  km[2],  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    chk("pin_z_r10", km[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    expand(KA, km);
    chk("pin_a_r1",  km[1],  128'hfa8807605fa82d0d3ac64e6553b2214f);
    chk("pin_a_r3",  km[3],  128'h180d2f1488d0819422cb6171db62a0db);
    chk("pin_a_r5",  km[5],  128'h881b4ab2ba265d8baad02bc36144fd50);
    chk("pin_a_r10", km[10], 128'hae127cdadb479ba8f220df3d4858f6b1);
    expand(KF, km);
    chk("pin_f_r10", km[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Zero key, full throughput, latency and done timing
    @(negedge clk);
    kick(128'h0);
    chk("lat_valid", 128'(rk_valid), 128'h1);
    chk("lat_round", 128'(rk_round), 128'h0);
    wait_done(30, n);
    chk("done_cycle", 128'(n + 1), 128'd12);
    @(negedge clk);

    // Backpressure at round 3
    kick(KA);
    chk("a_r0_echo", rk_data, KA);
    wait_round(3, 20);
    rk_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_data",  rk_data,        128'h180d2f1488d0819422cb6171db62a0db);
      chk("stall_round", 128'(rk_round), 128'd3);
    end
    rk_ready = 1'b1;
    wait_done(30, n);
    @(negedge clk);
    @(negedge clk);

    // Start during RUN is ignored, key_in changes do not leak in
    kick(KA);
    wait_round(4, 20);
    key_in = ~KA;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dn = 0;
    repeat (20) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    chk("single_done", 128'(dn), 128'd1);

    // Reset mid-run, with start asserted alongside
    kick(128'h0);
    wait_round(6, 20);
    reset  = 1'b1;
    start  = 1'b1;
    key_in = KA;
    @(negedge clk);
    chk("mid_rst_valid", 128'(rk_valid), 128'h0);
    chk("mid_rst_data",  rk_data,        128'h0);
    chk("mid_rst_round", 128'(rk_round), 128'h0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_ign", 128'(busy), 128'h0);
    kick(128'h0);
    wait_done(30, n);
    chk("rerun_done_cycle", 128'(n + 1), 128'd12);

    // Back-to-back: start in the first idle cycle after done
    @(negedge clk);
    kick(KA);
    wait_done(30, n);
    @(negedge clk);
    chk("b2b_idle", 128'(busy), 128'h0);
    kick(KF);
    chk("b2b_valid", 128'(rk_valid), 128'h1);
    chk("b2b_round", 128'(rk_round), 128'h0);
    chk("b2b_data",  rk_data,        KF);

    // Irregular consumer readiness
    n = 0;
    while (done !== 1'b1 && n < 80) begin
      rk_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    rk_ready = 1'b1;
    wait_done(30, n);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
